// File: rtl/trigger_gen_pkg.sv
// Shared types and helpers for the push-button trigger generator.
// The FSM state set and the shared counter width live here.
package trigger_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    FIRE,
    HELD,
    REL_DB,
    HOLDOFF
  } tg_state_t;

  // Width of the one counter shared by every state.
  function automatic int tg_cnt_w(
    input int d,
    input int h
  );
    int m;
    m = (d > h) ? d : h;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/trigger_gen_sync2.sv
// Two-flop synchronizer for the asynchronous button level.
// Both stages clear to 0 on reset, so a held button looks like a new press.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  // Shift the raw level through two flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/trigger_gen.sv
// Debounced push-button to single-cycle trigger pulse generator.
// Press and release are debounced, then a hold-off precedes re-arm.
module trigger_gen
  import trigger_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic trigger,
  output logic btn_level,
  output logic armed
);

  localparam int CW = tg_cnt_w(DEBOUNCE_CYCLES, HOLDOFF_CYCLES);
  localparam int HO_LAST_I =
    (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;

  localparam logic [CW-1:0] DB_N    = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] HO_LAST = CW'(HO_LAST_I);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] CMAX    = {CW{1'b1}};

  logic            s2;
  tg_state_t       state;
  tg_state_t       nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   nxt_cnt;
  logic [CW-1:0]   cnt_inc;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (s2)
  );

  // Saturating increment of the shared counter.
  assign cnt_inc = (cnt == CMAX) ? cnt : cnt + ONE;

  // Next-state and counter rules; D=1 completes on the entry sample.
  always_comb begin
    nxt     = state;
    nxt_cnt = cnt;
    unique case (state)
      IDLE: begin
        nxt_cnt = '0;
        if (s2) begin
          if (DEBOUNCE_CYCLES == 1) begin
            nxt = FIRE;
          end else begin
            nxt     = PRESS_DB;
            nxt_cnt = ONE;
          end
        end
      end
      PRESS_DB: begin
        if (!s2) begin
          nxt     = IDLE;
          nxt_cnt = '0;
        end else if (cnt_inc >= DB_N) begin
          nxt     = FIRE;
          nxt_cnt = '0;
        end else begin
          nxt_cnt = cnt_inc;
        end
      end
      FIRE: begin
        nxt     = HELD;
        nxt_cnt = '0;
      end
      HELD: begin
        nxt_cnt = '0;
        if (!s2) begin
          if (DEBOUNCE_CYCLES == 1) begin
            nxt = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
          end else begin
            nxt     = REL_DB;
            nxt_cnt = ONE;
          end
        end
      end
      REL_DB: begin
        if (s2) begin
          nxt     = HELD;
          nxt_cnt = '0;
        end else if (cnt_inc >= DB_N) begin
          nxt     = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
          nxt_cnt = '0;
        end else begin
          nxt_cnt = cnt_inc;
        end
      end
      HOLDOFF: begin
        if (cnt >= HO_LAST) begin
          nxt     = IDLE;
          nxt_cnt = '0;
        end else begin
          nxt_cnt = cnt_inc;
        end
      end
      default: begin
        nxt     = IDLE;
        nxt_cnt = '0;
      end
    endcase
  end

  // State, counter and outputs registered together from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      trigger   <= 1'b0;
      btn_level <= 1'b0;
      armed     <= 1'b1;
    end else begin
      state     <= nxt;
      cnt       <= nxt_cnt;
      trigger   <= (nxt == FIRE);
      btn_level <= (nxt == FIRE) || (nxt == HELD) ||
                   (nxt == REL_DB);
      armed     <= (nxt == IDLE);
    end
  end

endmodule
